rv32i_regfile_sb: RTL and testbench

RV32I_REGFILE_SB -- requirements
Module: rv32i_regfile_sb

---
 rtl/rv32i_regfile_sb.sv | 100 ++++++++++
 tb/tb_rv32i_regfile_sb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_regfile_sb.sv
// RV32I integer register file with synchronous read ports, a pending-write scoreboard
// and a post-reset sweep that zeroes every register before the file reports ready.
module rv32i_regfile_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_stall,
    input  logic [NRD*AW-1:0]   i_rs_addr,
    output logic [NRD*XLEN-1:0] o_rs,
    output logic [NRD-1:0]      o_rs_busy,
    input  logic                i_wr,
    input  logic [AW-1:0]       i_rd_addr,
    input  logic [XLEN-1:0]     i_rd,
    input  logic                i_iss,
    input  logic [AW-1:0]       i_iss_addr,
    output logic                o_ready
);

    typedef enum logic {INIT, READY} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [NRD*AW-1:0] rs_addr_q;
    logic [XLEN-1:0]   mem [NREG];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [XLEN-1:0]   mem_wdata;
    logic              ready;

    assign ready   = (state_q == READY);
    assign o_ready = ready;

    // State, sweep counter, scoreboard and latched read addresses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= INIT;
            cnt_q     <= AW'(1);
            busy_q    <= '0;
            rs_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            if (!i_stall) begin
                rs_addr_q <= i_rs_addr;
            end
        end
    end

    // Sweep owns the write port during INIT; afterwards user writes and issues apply
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = i_rd_addr;
        mem_wdata = i_rd;
        case (state_q)
            INIT: begin
                mem_we    = i_rst_n;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (i_wr && (i_rd_addr != '0)) begin
                    mem_we            = 1'b1;
                    busy_d[i_rd_addr] = 1'b0;
                end
                // Applied after the clear so a same-address issue keeps the bit set
                if (i_iss && (i_iss_addr != '0)) begin
                    busy_d[i_iss_addr] = 1'b1;
                end
            end
        endcase
    end

    // Storage has no reset so it maps onto distributed RAM
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rs_addr_q[k*AW +: AW];
        assign o_rs[k*XLEN +: XLEN] = (ready && (ra != '0)) ? mem[ra] : '0;
        assign o_rs_busy[k]         = ready & busy_q[ra];
    end

endmodule

// File: tb/tb_rv32i_regfile_sb.sv
// Bench for rv32i_regfile_sb: drives a default instance and an XLEN=64/NREG=16/NRD=3
// instance from the same stimulus, each checked against its own behavioural model.
module tb_rv32i_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, wr, iss;
    logic [4:0]  rd_addr, iss_addr;
    logic [63:0] rd_data;
    logic [4:0]  addr_in [3];

    logic [9:0]   a_rs_addr;
    logic [63:0]  a_rs;
    logic [1:0]   a_busy;
    logic         a_ready;
    logic [11:0]  b_rs_addr;
    logic [191:0] b_rs;
    logic [2:0]   b_busy;
    logic         b_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign a_rs_addr = {addr_in[1], addr_in[0]};
    assign b_rs_addr = {addr_in[2][3:0], addr_in[1][3:0], addr_in[0][3:0]};

    rv32i_regfile_sb u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_rs_addr(a_rs_addr),
        .o_rs(a_rs), .o_rs_busy(a_busy), .i_wr(wr), .i_rd_addr(rd_addr),
        .i_rd(rd_data[31:0]), .i_iss(iss), .i_iss_addr(iss_addr), .o_ready(a_ready)
    );

    rv32i_regfile_sb #(.XLEN(64), .NREG(16), .NRD(3)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_rs_addr(b_rs_addr),
        .o_rs(b_rs), .o_rs_busy(b_busy), .i_wr(wr), .i_rd_addr(rd_addr[3:0]),
        .i_rd(rd_data), .i_iss(iss), .i_iss_addr(iss_addr[3:0]), .o_ready(b_ready)
    );

    // Reference model: architectural register contents, pending set, latched addresses
    logic [63:0] m_mem   [2][32];
    bit          m_busy  [2][32];
    logic [4:0]  m_addr  [2][3];
    int          m_edges [2];
    bit          m_ready [2];

    function automatic int nreg_of(int c); return (c != 0) ? 16 : 32; endfunction
    function automatic int nrd_of(int c);  return (c != 0) ? 3 : 2;   endfunction
    function automatic logic [63:0] dmask(int c);
        return (c != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction
    function automatic logic [4:0] amask(int c, logic [4:0] a);
        return (c != 0) ? {1'b0, a[3:0]} : a;
    endfunction

    function automatic logic [63:0] exp_rs(int c, int k);
        logic [4:0] a = m_addr[c][k];
        return (m_ready[c] && a != 5'd0) ? m_mem[c][a] : 64'd0;
    endfunction
    function automatic logic exp_busy(int c, int k);
        return m_ready[c] && m_busy[c][m_addr[c][k]];
    endfunction

    function automatic logic [63:0] obs_rs(int c, int k);
        if (c == 0) return {32'd0, a_rs[k*32 +: 32]};
        return b_rs[k*64 +: 64];
    endfunction
    function automatic logic obs_busy(int c, int k);
        return (c != 0) ? b_busy[k] : a_busy[k];
    endfunction
    function automatic logic obs_ready(int c);
        return (c != 0) ? b_ready : a_ready;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_ready[c] = 1'b0;
            m_edges[c] = 0;
            for (int i = 0; i < 32; i++) begin
                m_mem[c][i]  = 64'd0;
                m_busy[c][i] = 1'b0;
            end
            for (int k = 0; k < 3; k++) m_addr[c][k] = 5'd0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        for (int c = 0; c < 2; c++) begin
            logic [4:0] ra = amask(c, rd_addr);
            logic [4:0] ia = amask(c, iss_addr);
            if (m_ready[c]) begin
                if (wr && ra != 5'd0) begin
                    m_mem[c][ra]  = rd_data & dmask(c);
                    m_busy[c][ra] = 1'b0;
                end
                if (iss && ia != 5'd0) m_busy[c][ia] = 1'b1;
            end else begin
                m_edges[c]++;
                if (m_edges[c] == nreg_of(c) - 1) m_ready[c] = 1'b1;
            end
            if (!stall)
                for (int k = 0; k < nrd_of(c); k++) m_addr[c][k] = amask(c, addr_in[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; wr = 1'b0; iss = 1'b0;
        rd_addr = 5'd0; iss_addr = 5'd0; rd_data = 64'd0;
        for (int k = 0; k < 3; k++) addr_in[k] = 5'd0;
    endtask

    task automatic set_addr(logic [4:0] a);
        for (int k = 0; k < 3; k++) addr_in[k] = a;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (obs_ready(c) !== 1'b0) $display("FAIL reset_ready cfg%0d: got %b want 0", c, obs_ready(c));
            else n_pass++;
            for (int k = 0; k < nrd_of(c); k++) begin
                n_checks++;
                if (obs_rs(c, k) !== 64'd0 || obs_busy(c, k) !== 1'b0)
                    $display("FAIL reset_out cfg%0d p%0d: got rs %h busy %b want 0/0", c, k, obs_rs(c, k), obs_busy(c, k));
                else n_pass++;
            end
        end
        #2 rst_n = 1'b1;
        // Writes and issues during the sweep must be dropped
        for (int e = 1; e <= 31; e++) begin
            for (int k = 0; k < 3; k++) addr_in[k] = 5'($urandom_range(0, 31));
            wr = (e < 15); iss = (e < 15);
            rd_addr = 5'($urandom_range(0, 31)); iss_addr = 5'($urandom_range(0, 31));
            rd_data = {$urandom, $urandom};
            step();
            n_checks++;
            if (a_ready !== (e >= 31) || b_ready !== (e >= 15))
                $display("FAIL sweep_ready edge%0d: got a=%b b=%b want a=%b b=%b", e, a_ready, b_ready, e >= 31, e >= 15);
            else n_pass++;
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < nrd_of(c); k++) begin
                    n_checks++;
                    if (obs_rs(c, k) !== 64'd0 || obs_busy(c, k) !== 1'b0)
                        $display("FAIL sweep_out cfg%0d p%0d edge%0d: got rs %h busy %b want 0/0", c, k, e, obs_rs(c, k), obs_busy(c, k));
                    else n_pass++;
                end
        end
        idle();
    endtask

    task automatic test_sweep_zero();
        for (int r = 0; r < 32; r++) begin
            set_addr(5'(r));
            step();
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < nrd_of(c); k++) begin
                    n_checks++;
                    if (obs_rs(c, k) !== 64'd0 || obs_busy(c, k) !== 1'b0)
                        $display("FAIL zero_after_sweep cfg%0d p%0d x%0d: got rs %h busy %b want 0/0", c, k, r, obs_rs(c, k), obs_busy(c, k));
                    else n_pass++;
                end
        end
        idle();
    endtask

    task automatic test_rw();
        wr = 1'b1; rd_addr = 5'd5; rd_data = 64'hCAFE_F00D_DEAD_BEEF; set_addr(5'd5);
        step();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < nrd_of(c); k++) begin
                n_checks++;
                if (obs_rs(c, k) !== (64'hCAFE_F00D_DEAD_BEEF & dmask(c)))
                    $display("FAIL write_first_x5 cfg%0d p%0d: got %h want %h", c, k, obs_rs(c, k), 64'hCAFE_F00D_DEAD_BEEF & dmask(c));
                else n_pass++;
            end
        rd_addr = 5'd0; rd_data = 64'h1234; set_addr(5'd0);
        step();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < nrd_of(c); k++) begin
                n_checks++;
                if (obs_rs(c, k) !== 64'd0) $display("FAIL x0_write cfg%0d p%0d: got %h want 0", c, k, obs_rs(c, k));
                else n_pass++;
            end
        idle();
    endtask

    task automatic test_busy();
        logic want [3] = '{1'b1, 1'b1, 1'b0};
        iss = 1'b1; iss_addr = 5'd7;
        step();
        iss = 1'b0; set_addr(5'd7);
        for (int ph = 0; ph < 3; ph++) begin
            if (ph == 1) begin wr = 1'b1; rd_addr = 5'd7; rd_data = 64'h55; iss = 1'b1; end
            if (ph == 2) iss = 1'b0;
            step();
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < nrd_of(c); k++) begin
                    n_checks++;
                    if (obs_busy(c, k) !== want[ph])
                        $display("FAIL busy_x7 phase%0d cfg%0d p%0d: got %b want %b", ph, c, k, obs_busy(c, k), want[ph]);
                    else n_pass++;
                end
        end
        n_checks++;
        if (a_rs[31:0] !== 32'h55) $display("FAIL x7_data: got %h want 00000055", a_rs[31:0]);
        else n_pass++;
        idle();
    endtask

    task automatic test_stall();
        wr = 1'b1; rd_addr = 5'd9; rd_data = 64'h99; set_addr(5'd3);
        step();
        stall = 1'b1; rd_addr = 5'd3; rd_data = 64'hA5A5_A5A5; set_addr(5'd9);
        step();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < nrd_of(c); k++) begin
                n_checks++;
                if (obs_rs(c, k) !== 64'hA5A5_A5A5) $display("FAIL stall_hold cfg%0d p%0d: got %h want a5a5a5a5", c, k, obs_rs(c, k));
                else n_pass++;
            end
        stall = 1'b0; wr = 1'b0;
        step();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < nrd_of(c); k++) begin
                n_checks++;
                if (obs_rs(c, k) !== 64'h99) $display("FAIL stall_release cfg%0d p%0d: got %h want 99", c, k, obs_rs(c, k));
                else n_pass++;
            end
        idle();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < 3; k++)
                addr_in[k] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            stall = ($urandom_range(0, 3) == 0);
            wr = ($urandom_range(0, 1) != 0); iss = ($urandom_range(0, 1) != 0);
            rd_addr = 5'($urandom_range(0, 7)); iss_addr = 5'($urandom_range(0, 7));
            rd_data = {$urandom, $urandom};
            step();
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < nrd_of(c); k++) begin
                    n_checks++;
                    if (obs_rs(c, k) !== exp_rs(c, k) || obs_busy(c, k) !== exp_busy(c, k))
                        $display("FAIL random cyc%0d cfg%0d p%0d: got rs %h busy %b want %h/%b", cyc, c, k, obs_rs(c, k), obs_busy(c, k), exp_rs(c, k), exp_busy(c, k));
                    else n_pass++;
                end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        wr = 1'b1; rd_addr = 5'd4; rd_data = 64'h11; iss = 1'b1; iss_addr = 5'd6; set_addr(5'd4);
        step();
        wr = 1'b0; iss = 1'b0; addr_in[1] = 5'd6;
        step();
        n_checks++;
        if (a_rs[31:0] !== 32'h11 || a_busy !== 2'b10) $display("FAIL pre_reset: got rs %h busy %b want 11/10", a_rs[31:0], a_busy);
        else n_pass++;
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0 || a_rs !== 64'd0 || b_rs !== 192'd0 || a_busy !== 2'd0 || b_busy !== 3'd0)
            $display("FAIL async_reset: got ready %b%b busy %b/%b rs nonzero=%b want all 0", a_ready, b_ready, a_busy, b_busy, (a_rs != 0) || (b_rs != 0));
        else n_pass++;
        #2 rst_n = 1'b1;
        for (int e = 1; e <= 42; e++) begin
            if (e == 10) begin
                rst_n = 1'b0; model_reset(); #2 rst_n = 1'b1;
            end
            step();
            n_checks++;
            if (a_ready !== m_ready[0] || b_ready !== m_ready[1])
                $display("FAIL resweep_ready edge%0d: got a=%b b=%b want a=%b b=%b", e, a_ready, b_ready, m_ready[0], m_ready[1]);
            else n_pass++;
        end
        set_addr(5'd4); addr_in[1] = 5'd6;
        step();
        n_checks++;
        if (a_rs[31:0] !== 32'd0 || b_rs[63:0] !== 64'd0 || a_busy !== 2'd0)
            $display("FAIL x4_after_reset: got a %h b %h busy %b want 0/0/00", a_rs[31:0], b_rs[63:0], a_busy);
        else n_pass++;
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        test_reset();
        test_sweep_zero();
        test_rw();
        test_busy();
        test_stall();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
